rate_limiter_ingress_arbiter: RTL and testbench

RATE_LIMITER_INGRESS_ARBITER -- requirements
Module: rate_limiter_ingress_arbiter

---
 rtl/rate_limiter_ingress_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_rate_limiter_ingress_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_limiter_ingress_arbiter.sv
// rate_limiter_ingress_arbiter
//   Round-robin arbiter that funnels N_PORTS ingress requesters into a single
//   token-bucket limiter and routes the limiter's accept/drop verdict back to
//   the requesting port. A pause handshake lets software quiesce the path:
//   new grants stop, in-flight requests finish, then pause_ack rises.
//
//   Timing of one request granted in cycle T:
//     T   : req_valid[i] & req_ready[i]
//     T+1 : pkt_valid / pkt_client_id to the limiter
//     T+2 : pkt_accept / pkt_drop sampled
//     T+3 : resp_valid / resp_port / resp_accept
//
//   Optional feature macro: ARB_DROP_CNT_EN
//     defined   -> per-port saturating drop counters, readable via cnt_rd_port
//     undefined -> no counters, cnt_rd_data reads 0
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_client_id   per-port requests
//   req_ready                 per-port grant (one-hot or zero)
//   pkt_valid/pkt_client_id   request to the limiter
//   pkt_accept/pkt_drop       limiter verdict, one cycle after pkt_valid
//   resp_valid/port/accept    verdict returned to the owning port
//   pause_req/pause_ack       quiesce request / quiesced indicator
//   err_protocol/err_clr      sticky limiter-protocol error and its clear
//   cnt_rd_port/cnt_rd_data   drop counter read port

`timescale 1ns/1ps

`ifdef ARB_DROP_CNT_EN
// Per-port saturating drop counter.
module rate_limiter_ingress_arbiter_drop_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end
endmodule
`endif

module rate_limiter_ingress_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int N_CLIENTS = 1024,
    parameter int CLIENT_W  = $clog2(N_CLIENTS),
    parameter int PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    parameter int CNT_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_PORTS-1:0]                 req_valid,
    input  logic [N_PORTS-1:0][CLIENT_W-1:0]   req_client_id,
    output logic [N_PORTS-1:0]                 req_ready,
    output logic                               pkt_valid,
    output logic [CLIENT_W-1:0]                pkt_client_id,
    input  logic                               pkt_accept,
    input  logic                               pkt_drop,
    output logic                               resp_valid,
    output logic [PORT_W-1:0]                  resp_port,
    output logic                               resp_accept,
    input  logic                               pause_req,
    output logic                               pause_ack,
    output logic                               err_protocol,
    input  logic                               err_clr,
    input  logic [PORT_W-1:0]                  cnt_rd_port,
    output logic [CNT_W-1:0]                   cnt_rd_data
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int STAGES = 2;

    state_t                       state, state_nxt;
    logic [PORT_W-1:0]            rr_ptr;
    logic [PORT_W-1:0]            grant_idx;
    logic                         grant_any;
    logic                         hs;
    logic [PORT_W:0]              cand;
    logic                         proto_err;

    // vld_pipe[1] is the request on the limiter bus, vld_pipe[2] marks the
    // cycle in which a verdict is expected; port_pipe follows alongside.
    logic [STAGES:1]              vld_pipe;
    logic [STAGES:1][PORT_W-1:0]  port_pipe;

    // Round-robin search starting at rr_ptr. cand carries one extra bit so the
    // wrap can be done by a single subtract for any N_PORTS.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, rr_ptr} + (PORT_W+1)'(k);
            if (cand >= (PORT_W+1)'(N_PORTS))
                cand = cand - (PORT_W+1)'(N_PORTS);
            if (!grant_any && req_valid[cand[PORT_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PORT_W-1:0];
            end
        end
    end

    // The winner always has req_valid high, so a grant is a handshake.
    assign hs = (state == RUN) && grant_any;

    always_comb begin
        req_ready = '0;
        if (hs)
            req_ready[grant_idx] = 1'b1;
    end

    // A verdict must be exactly one of accept/drop when expected, and neither
    // when nothing is in flight.
    assign proto_err = vld_pipe[2] ? (pkt_accept == pkt_drop)
                                   : (pkt_accept | pkt_drop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            vld_pipe      <= '0;
            port_pipe     <= '0;
            pkt_client_id <= '0;
            resp_valid    <= 1'b0;
            resp_port     <= '0;
            resp_accept   <= 1'b0;
            err_protocol  <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr        <= (grant_idx == PORT_W'(N_PORTS - 1)) ? '0
                                                                     : grant_idx + PORT_W'(1);
                pkt_client_id <= req_client_id[grant_idx];
            end
            vld_pipe    <= {vld_pipe[1], hs};
            port_pipe   <= {port_pipe[1], grant_idx};
            resp_valid  <= vld_pipe[2];
            resp_port   <= vld_pipe[2] ? port_pipe[2] : '0;
            resp_accept <= vld_pipe[2] & pkt_accept & ~pkt_drop;
            if (proto_err)
                err_protocol <= 1'b1;
            else if (err_clr)
                err_protocol <= 1'b0;
        end
    end

    assign pkt_valid = vld_pipe[1];

    // Pause FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:    if (pause_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!pause_req)
                    state_nxt = RUN;
                else if (!vld_pipe[1] && !vld_pipe[2] && !resp_valid)
                    state_nxt = PAUSED;
            end
            PAUSED: if (!pause_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign pause_ack = (state == PAUSED);

`ifdef ARB_DROP_CNT_EN
    logic [N_PORTS-1:0][CNT_W-1:0] drop_cnt;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        rate_limiter_ingress_arbiter_drop_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (resp_valid && !resp_accept && (resp_port == PORT_W'(p))),
            .cnt (drop_cnt[p])
        );
    end

    assign cnt_rd_data = (int'(cnt_rd_port) < N_PORTS) ? drop_cnt[cnt_rd_port] : '0;
`else
    logic unused_rd;
    assign unused_rd   = ^cnt_rd_port;
    assign cnt_rd_data = '0;
`endif

endmodule

// File: tb/tb_rate_limiter_ingress_arbiter.sv
`timescale 1ns/1ps

module tb_rate_limiter_ingress_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][9:0]  req_client_id;
    logic [3:0]       req_ready;
    logic             pkt_valid;
    logic [9:0]       pkt_client_id;
    logic             pkt_accept, pkt_drop;
    logic             resp_valid;
    logic [1:0]       resp_port;
    logic             resp_accept;
    logic             pause_req, pause_ack;
    logic             err_protocol, err_clr;
    logic [1:0]       cnt_rd_port;
    logic [1:0]       cnt_rd_data;

    rate_limiter_ingress_arbiter #(
        .N_PORTS(4), .N_CLIENTS(1024), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_client_id(req_client_id), .req_ready(req_ready),
        .pkt_valid(pkt_valid), .pkt_client_id(pkt_client_id),
        .pkt_accept(pkt_accept), .pkt_drop(pkt_drop),
        .resp_valid(resp_valid), .resp_port(resp_port), .resp_accept(resp_accept),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .err_protocol(err_protocol), .err_clr(err_clr),
        .cnt_rd_port(cnt_rd_port), .cnt_rd_data(cnt_rd_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int cyc; } pkt_exp_t;
    typedef struct { int port; int acc; int cyc; } resp_exp_t;
    pkt_exp_t  pkt_q[$];
    resp_exp_t resp_q[$];
    pkt_exp_t  pe;
    resp_exp_t re;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Limiter model: verdict one cycle after pkt_valid; odd client IDs drop.
    logic lim_pend = 1'b0, lim_odd = 1'b0, lim_acc = 1'b0, lim_drop = 1'b0;
    logic force_acc;
    always @(negedge clk) begin
        lim_pend <= pkt_valid;
        lim_odd  <= pkt_client_id[0];
    end
    always @(posedge clk) begin
        lim_acc  <= lim_pend & ~lim_odd;
        lim_drop <= lim_pend & lim_odd;
    end
    assign pkt_accept = lim_acc | force_acc;
    assign pkt_drop   = lim_drop;

    // Monitor: compares every cycle against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_q.size() > 0 && pkt_q[0].cyc == cyc) begin
                chk("pkt_valid", pkt_valid, 1);
                pe = pkt_q.pop_front();
                chk("pkt_client_id", pkt_client_id, pe.id);
            end else begin
                chk("pkt_valid_idle", pkt_valid, 0);
            end
            if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
                chk("resp_valid", resp_valid, 1);
                re = resp_q.pop_front();
                chk("resp_port", resp_port, re.port);
                chk("resp_accept", resp_accept, re.acc);
            end else begin
                chk("resp_valid_idle", resp_valid, 0);
            end
        end
    end

    // One cycle: check the grant, queue the expected downstream traffic.
    task automatic step(input logic [3:0] exp_rdy, input bit push_pkt,
                        input bit push_resp, input int acc, input string nm);
        @(negedge clk);
        chk(nm, req_ready, exp_rdy);
        for (int p = 0; p < 4; p++) begin
            if (exp_rdy[p]) begin
                if (push_pkt)  pkt_q.push_back('{id: int'(req_client_id[p]), cyc: cyc + 1});
                if (push_resp) resp_q.push_back('{port: p, acc: acc, cyc: cyc + 3});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_pause(input logic exp_ack);
        @(negedge clk);
        chk("pause_ready", req_ready, 0);
        chk("pause_ack", pause_ack, exp_ack);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_client_id = '0; pause_req = 1'b0;
        err_clr = 1'b0; force_acc = 1'b0; cnt_rd_port = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_pause_ack", pause_ack, 0);
        chk("rst_err", err_protocol, 0);
        chk("rst_cnt", cnt_rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // All ports busy: strict 0,1,2,3 rotation, all accepted
        req_client_id[0] = 10'd100; req_client_id[1] = 10'd102;
        req_client_id[2] = 10'd104; req_client_id[3] = 10'd106;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++)
            step(4'b0001 << (k % 4), 1, 1, 1, "rr_grant");
        req_valid = '0;
        idle(4);

        // Single port 2, client 5, dropped by the limiter
        req_client_id[2] = 10'd5;
        req_valid = 4'b0100;
        step(4'b0100, 1, 1, 0, "single_grant");
        req_valid = '0;
        idle(4);

        // Pause right after a handshake; rr_ptr is 3 here so port 1 wins
        req_client_id[0] = 10'd20; req_client_id[1] = 10'd8;
        req_client_id[2] = 10'd34; req_client_id[3] = 10'd46;
        req_valid = 4'b0010;
        step(4'b0010, 1, 1, 1, "pre_pause_grant");
        req_valid = '0;
        pause_req = 1'b1;
        chk_pause(1'b0);
        req_valid = 4'hF;
        chk_pause(1'b0);
        chk_pause(1'b0);   // response cycle
        chk_pause(1'b0);
        chk_pause(1'b1);
        chk_pause(1'b1);
        pause_req = 1'b0;
        chk_pause(1'b1);
        step(4'b0100, 1, 1, 1, "resume_grant");
        req_valid = '0;
        idle(4);
        @(negedge clk);
        chk("err_after_traffic", err_protocol, 0);
        @(posedge clk); #1;

        // Protocol error: accept with nothing in flight
        force_acc = 1'b1;
        @(negedge clk); chk("err_before", err_protocol, 0);
        @(posedge clk); #1;
        force_acc = 1'b0;
        @(negedge clk); chk("err_set", err_protocol, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("err_sticky", err_protocol, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk); chk("err_clr_same", err_protocol, 1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk); chk("err_cleared", err_protocol, 0);
        @(posedge clk); #1;
        force_acc = 1'b1; err_clr = 1'b1;
        @(posedge clk); #1;
        force_acc = 1'b0; err_clr = 1'b0;
        @(negedge clk); chk("err_set_wins", err_protocol, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk); chk("err_cleared2", err_protocol, 0);
        @(posedge clk); #1;

        // Port 1 dropped five times
        req_client_id[1] = 10'd7;
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++)
            step(4'b0010, 1, 1, 0, "drop_grant");
        req_valid = '0;
        idle(4);
`ifdef ARB_DROP_CNT_EN
        cnt_rd_port = 2'd1; @(negedge clk); chk("cnt_port1_sat", cnt_rd_data, 3);
        @(posedge clk); #1;
        cnt_rd_port = 2'd0; @(negedge clk); chk("cnt_port0", cnt_rd_data, 0);
        @(posedge clk); #1;
        cnt_rd_port = 2'd2; @(negedge clk); chk("cnt_port2", cnt_rd_data, 1);
        @(posedge clk); #1;
`else
        cnt_rd_port = 2'd1; @(negedge clk); chk("cnt_off_port1", cnt_rd_data, 0);
        @(posedge clk); #1;
        cnt_rd_port = 2'd2; @(negedge clk); chk("cnt_off_port2", cnt_rd_data, 0);
        @(posedge clk); #1;
`endif

        // Reset with two requests in flight; rr_ptr is 2 here
        req_client_id[0] = 10'd40; req_client_id[3] = 10'd42;
        req_valid = 4'b1001;
        step(4'b1000, 1, 0, 0, "inflight_grant_a");
        step(4'b0001, 0, 0, 0, "inflight_grant_b");
        rst = 1'b1; req_valid = '0;
        @(negedge clk);
        chk("mid_rst_pkt_valid", pkt_valid, 0);
        chk("mid_rst_pkt_id", pkt_client_id, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_port", resp_port, 0);
        chk("mid_rst_resp_accept", resp_accept, 0);
        chk("mid_rst_pause_ack", pause_ack, 0);
        chk("mid_rst_err", err_protocol, 0);
        chk("mid_rst_ready", req_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        req_client_id[0] = 10'd50; req_client_id[1] = 10'd52;
        req_client_id[2] = 10'd54; req_client_id[3] = 10'd56;
        req_valid = 4'hF;
        step(4'b0001, 1, 1, 1, "post_rst_rr_ptr0");
        req_valid = '0;
        idle(6);

        chk("pkt_q_drained", pkt_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("err_final", err_protocol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
